sccb_responder: RTL and testbench

// - SCCB slave (camera-side) endpoint: decodes 3-phase write, 2-phase write and 2-phase read cycles from SCCB_CTRL.
// - Presents register accesses to an external 8-bit register bank. Serves as the OV2640 stand-in for SCCB_CTRL bring-up and as the FPGA-side config port.
// - All logic runs on XCLK. SIO_C/SIO_D are oversampled; SIO_C never clocks a flop.

---
 rtl/sccb_pkg.sv | 24 ++
 rtl/sccb_line_sync.sv | 62 ++++++
 rtl/sccb_responder.sv | 204 ++++++++++++++++++++
 tb/tb_sccb_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, byte geometry and the R/W bit polarity.
package sccb_pkg;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic SCCB_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_NA,
        WAIT_STOP
    } sccb_state_e;

    function automatic logic byte_done(input logic [2:0] cnt);
        return cnt == 3'(BITS_PER_BYTE - 1);
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SIO_C/SIO_D into XCLK and produces registered SCL edge and START/STOP pulses.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   sda_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Idle bus is high on both lines, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_q      <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            sda_q      <= sda_s;
            rise_q     <= scl_s & ~scl_prev_q;
            fall_q     <= ~scl_s & scl_prev_q;
            start_q    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
            stop_q     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        end
    end

    assign sda_o      = sda_q;
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave endpoint presenting 3-phase/2-phase writes and 2-phase reads to an 8-bit register bank.
// Define SCCB_ACK_EN to pull SIO_D low during the 9th bit of each accepted phase.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = 7'h30,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       XCLK,
    input  logic       RST,
    input  logic       SIO_C,
    inout  wire        SIO_D,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

`ifdef SCCB_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i      (XCLK),
        .rst_i      (RST),
        .scl_i      (SIO_C),
        .sda_i      (SIO_D),
        .sda_o      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    sccb_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        rw_q, rw_d;
    logic        seen9_q, seen9_d;
    logic        drv_q, drv_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic [7:0]  byte_in;

    assign byte_in = {sh_q[6:0], sda};

    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 8'h00;
            rw_q    <= 1'b0;
            seen9_q <= 1'b0;
            drv_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rw_q    <= rw_d;
            seen9_q <= seen9_d;
            drv_q   <= drv_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rw_d    = rw_q;
        seen9_d = seen9_q;
        drv_d   = drv_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;

        if (start_det) begin
            // Covers both a fresh START and a repeated START mid-transaction.
            state_d = ID;
            cnt_d   = 3'd0;
            seen9_d = 1'b0;
            drv_d   = 1'b0;
            busy_d  = 1'b1;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            seen9_d = 1'b0;
            drv_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ID, SUB, WDATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 3'd1;
                        if (byte_done(cnt_q)) begin
                            seen9_d = 1'b0;
                            unique case (state_q)
                                ID: begin
                                    if (byte_in[7:1] == DEV_ID) begin
                                        rw_d    = byte_in[0];
                                        state_d = ID_ACK;
                                    end else begin
                                        state_d = WAIT_STOP;
                                    end
                                end
                                SUB: begin
                                    addr_d  = byte_in;
                                    state_d = SUB_ACK;
                                end
                                default: begin
                                    wdata_d = byte_in;
                                    wr_d    = 1'b1;
                                    state_d = WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    // First fall opens the 9th bit, the fall after its rise closes it.
                    if (scl_rise) begin
                        seen9_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!seen9_q) begin
                            drv_d = ACK_DRIVE;
                        end else begin
                            drv_d   = 1'b0;
                            seen9_d = 1'b0;
                            cnt_d   = 3'd0;
                            unique case (state_q)
                                ID_ACK: begin
                                    if (rw_q == SCCB_RW_READ) begin
                                        state_d = RDATA;
                                        sh_d    = reg_rdata;
                                        drv_d   = ~reg_rdata[7];
                                    end else begin
                                        state_d = SUB;
                                    end
                                end
                                SUB_ACK: state_d = WDATA;
                                default: state_d = WAIT_STOP;
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (byte_done(cnt_q)) begin
                            state_d = RD_NA;
                            drv_d   = 1'b0;
                            cnt_d   = 3'd0;
                            seen9_d = 1'b0;
                        end else begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            drv_d = ~sh_q[6];
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                RD_NA: begin
                    drv_d = 1'b0;
                    if (scl_rise) begin
                        seen9_d = 1'b1;
                    end else if (scl_fall && seen9_q) begin
                        seen9_d = 1'b0;
                        state_d = WAIT_STOP;
                    end
                end
                default: begin
                    drv_d = 1'b0;
                end
            endcase
        end
    end

    assign SIO_D     = drv_q ? 1'b0 : 1'bz;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bus master model with pull-up, and a bank returning ~reg_addr.
module tb_sccb_responder;

    // SCL scaled to 1 MHz (quarter period in XCLK cycles) to keep runtime short.
    localparam int QTR = 25;
`ifdef SCCB_ACK_EN
    localparam logic ACK_EXP = 1'b0;
`else
    localparam logic ACK_EXP = 1'b1;
`endif

    logic       xclk = 1'b0;
    logic       rst  = 1'b1;
    logic       scl  = 1'b1;
    logic       m_low = 1'b0;
    wire        sio_d;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_wr_en;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int slave_lows = 0;

    assign sio_d = m_low ? 1'b0 : 1'bz;
    pullup (sio_d);
    assign reg_rdata = ~reg_addr;

    always #5 xclk = ~xclk;

    always @(negedge xclk) begin
        if (reg_wr_en === 1'b1) wr_pulses = wr_pulses + 1;
        if (sio_d === 1'b0 && !m_low) slave_lows = slave_lows + 1;
    end

    sccb_responder #(
        .DEV_ID      (7'h30),
        .SYNC_STAGES (2)
    ) dut (
        .XCLK      (xclk),
        .RST       (rst),
        .SIO_C     (scl),
        .SIO_D     (sio_d),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic wait_q();
        repeat (QTR) @(negedge xclk);
    endtask

    task automatic sccb_start();
        if (scl) begin
            m_low = 1'b1; wait_q();
            scl = 1'b0;   wait_q();
        end else begin
            m_low = 1'b0; wait_q();
            scl = 1'b1;   wait_q();
            m_low = 1'b1; wait_q();
            scl = 1'b0;   wait_q();
        end
    endtask

    task automatic sccb_stop();
        m_low = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b0; wait_q();
        wait_q();
    endtask

    // One bit: data set while SCL low, level reported only if stable over the whole high period.
    task automatic clk_bit(input logic b, output logic lvl);
        logic first;
        logic stable;
        m_low = ~b;
        wait_q();
        scl = 1'b1;
        @(negedge xclk);
        first  = sio_d;
        stable = 1'b1;
        repeat (2*QTR-1) begin
            @(negedge xclk);
            if (sio_d !== first) stable = 1'b0;
        end
        scl = 1'b0;
        wait_q();
        lvl = stable ? first : 1'bx;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], dummy);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic na);
        logic bitv;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, bitv);
            d[i] = bitv;
        end
        clk_bit(1'b1, na);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge xclk);
        n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_vec++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata: got %h want 00", reg_wdata); end
        n_vec++; if (reg_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", reg_wr_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (sio_d !== 1'b1) begin n_err++; $display("FAIL rst_sio_d: got %b want 1", sio_d); end
        rst = 1'b0;
        repeat (5) @(negedge xclk);
    endtask

    task automatic test_read_default();
        logic ack, na;
        logic [7:0] d;
        sccb_start();
        send_byte(8'h61, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL rd0_id_ack: got %b want %b", ack, ACK_EXP); end
        recv_byte(d, na);
        n_vec++; if (d !== 8'hFF) begin n_err++; $display("FAIL rd0_data: got %h want FF", d); end
        n_vec++; if (na !== 1'b1) begin n_err++; $display("FAIL rd0_na: got %b want 1", na); end
        sccb_stop();
    endtask

    task automatic test_write3();
        logic ack;
        int w0;
        w0 = wr_pulses;
        sccb_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL w3_busy_start: got %b want 1", busy); end
        send_byte(8'h60, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL w3_id_ack: got %b want %b", ack, ACK_EXP); end
        send_byte(8'hEE, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL w3_sub_ack: got %b want %b", ack, ACK_EXP); end
        send_byte(8'hA5, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL w3_data_ack: got %b want %b", ack, ACK_EXP); end
        sccb_stop();
        repeat (10) @(negedge xclk);
        n_vec++; if (wr_pulses - w0 != 1) begin n_err++; $display("FAIL w3_strobes: got %0d want 1", wr_pulses - w0); end
        n_vec++; if (reg_addr !== 8'hEE) begin n_err++; $display("FAIL w3_addr: got %h want EE", reg_addr); end
        n_vec++; if (reg_wdata !== 8'hA5) begin n_err++; $display("FAIL w3_wdata: got %h want A5", reg_wdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL w3_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_write2_read();
        logic ack, na;
        logic [7:0] d;
        int w0;
        w0 = wr_pulses;
        sccb_start();
        send_byte(8'h60, ack);
        send_byte(8'h1C, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL w2_sub_ack: got %b want %b", ack, ACK_EXP); end
        sccb_stop();
        repeat (10) @(negedge xclk);
        n_vec++; if (wr_pulses - w0 != 0) begin n_err++; $display("FAIL w2_strobes: got %0d want 0", wr_pulses - w0); end
        n_vec++; if (reg_addr !== 8'h1C) begin n_err++; $display("FAIL w2_addr: got %h want 1C", reg_addr); end
        sccb_start();
        send_byte(8'h61, ack);
        recv_byte(d, na);
        n_vec++; if (d !== 8'hE3) begin n_err++; $display("FAIL rd_data: got %h want E3", d); end
        n_vec++; if (na !== 1'b1) begin n_err++; $display("FAIL rd_na: got %b want 1", na); end
        sccb_stop();
    endtask

    task automatic test_bad_id();
        logic ack;
        int w0, s0;
        w0 = wr_pulses;
        s0 = slave_lows;
        sccb_start();
        send_byte(8'h42, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL bad_id_ack: got %b want 1", ack); end
        send_byte(8'h55, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL bad_sub_ack: got %b want 1", ack); end
        sccb_stop();
        repeat (10) @(negedge xclk);
        n_vec++; if (slave_lows - s0 != 0) begin n_err++; $display("FAIL bad_slave_drive: got %0d low cycles want 0", slave_lows - s0); end
        n_vec++; if (wr_pulses - w0 != 0) begin n_err++; $display("FAIL bad_strobes: got %0d want 0", wr_pulses - w0); end
        n_vec++; if (reg_addr !== 8'h1C) begin n_err++; $display("FAIL bad_addr: got %h want 1C", reg_addr); end
    endtask

    task automatic test_rep_start();
        logic ack, na;
        logic [7:0] d;
        int w0;
        w0 = wr_pulses;
        sccb_start();
        send_byte(8'h60, ack);
        send_byte(8'hEE, ack);
        sccb_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rs_busy: got %b want 1", busy); end
        send_byte(8'h61, ack);
        n_vec++; if (ack !== ACK_EXP) begin n_err++; $display("FAIL rs_id_ack: got %b want %b", ack, ACK_EXP); end
        recv_byte(d, na);
        n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL rs_data: got %h want 11", d); end
        sccb_stop();
        repeat (10) @(negedge xclk);
        n_vec++; if (wr_pulses - w0 != 0) begin n_err++; $display("FAIL rs_strobes: got %0d want 0", wr_pulses - w0); end
    endtask

    task automatic test_partial_wdata();
        logic ack, dummy;
        int w0;
        w0 = wr_pulses;
        sccb_start();
        send_byte(8'h60, ack);
        send_byte(8'h33, ack);
        clk_bit(1'b1, dummy);
        clk_bit(1'b0, dummy);
        clk_bit(1'b1, dummy);
        clk_bit(1'b0, dummy);
        sccb_stop();
        repeat (10) @(negedge xclk);
        n_vec++; if (wr_pulses - w0 != 0) begin n_err++; $display("FAIL part_strobes: got %0d want 0", wr_pulses - w0); end
        n_vec++; if (reg_addr !== 8'h33) begin n_err++; $display("FAIL part_addr: got %h want 33", reg_addr); end
        n_vec++; if (reg_wdata !== 8'hA5) begin n_err++; $display("FAIL part_wdata: got %h want A5", reg_wdata); end
    endtask

    task automatic test_rst_mid_read();
        logic ack, b;
        sccb_start();
        send_byte(8'h61, ack);
        clk_bit(1'b1, b);
        n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL rr_bit7: got %b want 1", b); end
        clk_bit(1'b1, b);
        n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL rr_bit6: got %b want 1", b); end
        n_vec++; if (sio_d !== 1'b0) begin n_err++; $display("FAIL rr_bit5_driven: got %b want 0", sio_d); end
        rst = 1'b1;
        #1;
        n_vec++; if (sio_d !== 1'b1) begin n_err++; $display("FAIL rr_sio_release: got %b want 1", sio_d); end
        n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL rr_addr: got %h want 00", reg_addr); end
        n_vec++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL rr_wdata: got %h want 00", reg_wdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy: got %b want 0", busy); end
        n_vec++; if (reg_wr_en !== 1'b0) begin n_err++; $display("FAIL rr_wr_en: got %b want 0", reg_wr_en); end
        @(negedge xclk);
        rst = 1'b0;
        repeat (5) @(negedge xclk);
        sccb_stop();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_read_default();
        test_write3();
        test_write2_read();
        test_bad_id();
        test_rep_start();
        test_partial_wdata();
        test_rst_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
